// File: rtl/fusion_array_tile.sv
// Registered bit-fusion GEMM tile: cfg/weight/activation streaming into an inline systolic column
// model, per-column accumulation over a tile, held result. Optional ACC_SAT_EN: saturating accumulators.

module fusion_array_col #(
  parameter int N          = 8,
  parameter int PW         = 52,
  parameter int ACC_WIDTH  = 64,
  parameter int SA_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0][7:0]    act,
  input  logic [N-1:0][7:0]    wcol,
  input  logic [3:0]           in_w,
  input  logic [3:0]           wt_w,
  input  logic                 s_in,
  input  logic                 s_wt,
  input  logic                 acc_clr,
  input  logic                 acc_en,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 sat_evt
);
  // Operand uses the low w bits of its byte; widths arrive already coerced to 1/2/4/8.
  function automatic logic signed [8:0] dec(input logic [7:0] b, input logic [3:0] w, input logic s);
    case (w)
      4'd1:    dec = {{8{s & b[0]}}, b[0]};
      4'd2:    dec = {{7{s & b[1]}}, b[1:0]};
      4'd4:    dec = {{5{s & b[3]}}, b[3:0]};
      default: dec = {s & b[7], b};
    endcase
  endfunction

  function automatic logic signed [17:0] pe(input logic [7:0] a, input logic [7:0] w,
                                            input logic [3:0] aw, input logic [3:0] ww,
                                            input logic sa, input logic sw);
    pe = dec(a, aw, sa) * dec(w, ww, sw);
  endfunction

  logic signed [PW-1:0]   dot;
  logic        [PW-1:0]   psum_pipe [SA_LATENCY];
  logic        [PW-1:0]   psum_fwd;
  logic [ACC_WIDTH-1:0]   ext, acc_nxt;
  logic                   sgn, sat;

  always_comb begin
    dot = '0;
    for (int r = 0; r < N; r++)
      dot = dot + PW'(pe(act[r], wcol[r], in_w, wt_w, s_in, s_wt));
  end

  assign psum_fwd = psum_pipe[SA_LATENCY-1];
  assign sgn      = s_in | s_wt;
  assign ext      = sgn ? {{(ACC_WIDTH-PW){psum_fwd[PW-1]}}, psum_fwd}
                        : {{(ACC_WIDTH-PW){1'b0}}, psum_fwd};

`ifdef ACC_SAT_EN
  logic [ACC_WIDTH:0] wide;
  always_comb begin
    sat     = 1'b0;
    wide    = '0;
    acc_nxt = '0;
    if (sgn) begin
      wide = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
      if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
        sat     = 1'b1;
        acc_nxt = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else
        acc_nxt = wide[ACC_WIDTH-1:0];
    end else begin
      wide = {1'b0, acc} + {1'b0, ext};
      if (wide[ACC_WIDTH]) begin
        sat     = 1'b1;
        acc_nxt = '1;
      end else
        acc_nxt = wide[ACC_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    sat     = 1'b0;
    acc_nxt = acc + ext;
  end
`endif

  assign sat_evt = acc_en & sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SA_LATENCY; k++) psum_pipe[k] <= '0;
      acc <= '0;
    end else begin
      psum_pipe[0] <= dot;
      for (int k = 1; k < SA_LATENCY; k++) psum_pipe[k] <= psum_pipe[k-1];
      if (acc_clr)     acc <= '0;
      else if (acc_en) acc <= acc_nxt;
    end
  end
endmodule

module fusion_array_tile #(
  parameter int ARRAY_SIZE = 8,
  parameter int COL_WIDTH  = 13,
  parameter int ACC_WIDTH  = 64,
  parameter int SA_LATENCY = 2,
  parameter int MAX_BEATS  = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [3:0]                       cfg_in_width,
  input  logic [3:0]                       cfg_weight_width,
  input  logic                             cfg_s_in,
  input  logic                             cfg_s_weight,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*8-1:0] w_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*8-1:0]          in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data,
  output logic                             busy,
  output logic                             err
);
  localparam int N  = ARRAY_SIZE;
  localparam int PW = COL_WIDTH * 4;
  localparam int BW = $clog2(MAX_BEATS);
  localparam int DW = $clog2(SA_LATENCY + 2);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, HOLD} state_t;

  state_t                        state;
  logic [3:0]                    in_w, wt_w;
  logic                          s_in, s_wt;
  logic [N-1:0][N-1:0][7:0]      weight_reg;
  logic [N-1:0][N-1:0][7:0]      wcols;
  logic [N-1:0][7:0]             in_reg;
  logic [SA_LATENCY:0]           vld_pipe;
  logic [N-1:0][ACC_WIDTH-1:0]   acc;
  logic [N-1:0]                  sat_evt;
  logic [BW-1:0]                 beat_cnt;
  logic [DW-1:0]                 drain_cnt;
  logic                          cfg_fire, w_fire, in_fire, out_fire;

  function automatic logic legal_w(input logic [3:0] w);
    legal_w = (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

  assign cfg_fire = cfg_valid & cfg_ready;
  assign w_fire   = w_valid & w_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign busy     = (state != IDLE);

  // Column c sees weight column c: byte r of the column is w[r][c].
  always_comb begin
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++)
        wcols[c][r] = weight_reg[r][c];
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    fusion_array_col #(.N(N), .PW(PW), .ACC_WIDTH(ACC_WIDTH), .SA_LATENCY(SA_LATENCY)) u_col (
      .clk, .rst_n,
      .act(in_reg), .wcol(wcols[c]),
      .in_w, .wt_w, .s_in, .s_wt,
      .acc_clr(cfg_fire), .acc_en(vld_pipe[SA_LATENCY]),
      .acc(acc[c]), .sat_evt(sat_evt[c])
    );
  end

  // vld_pipe[0] rides with in_reg; vld_pipe[SA_LATENCY] with the column psum output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_reg   <= '0;
      vld_pipe <= '0;
    end else begin
      in_reg   <= in_fire ? in_data : '0;
      vld_pipe <= {vld_pipe[SA_LATENCY-1:0], in_fire};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cfg_ready  <= 1'b1;
      w_ready    <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      err        <= 1'b0;
      in_w       <= 4'd8;
      wt_w       <= 4'd8;
      s_in       <= 1'b0;
      s_wt       <= 1'b0;
      weight_reg <= '0;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
    end else begin
      if (|sat_evt) err <= 1'b1;
      case (state)
        IDLE: if (cfg_fire) begin
          in_w      <= legal_w(cfg_in_width)     ? cfg_in_width     : 4'd8;
          wt_w      <= legal_w(cfg_weight_width) ? cfg_weight_width : 4'd8;
          s_in      <= cfg_s_in;
          s_wt      <= cfg_s_weight;
          if (!legal_w(cfg_in_width) || !legal_w(cfg_weight_width)) err <= 1'b1;
          beat_cnt  <= '0;
          cfg_ready <= 1'b0;
          w_ready   <= 1'b1;
          state     <= LOAD_W;
        end
        LOAD_W: if (w_fire) begin
          weight_reg <= w_data;
          w_ready    <= 1'b0;
          in_ready   <= 1'b1;
          state      <= STREAM;
        end
        STREAM: if (in_fire) begin
          beat_cnt <= beat_cnt + BW'(1);
          // Beat MAX_BEATS closes the tile even without in_last.
          if (in_last || beat_cnt == BW'(MAX_BEATS - 1)) begin
            if (!in_last) err <= 1'b1;
            in_ready  <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(SA_LATENCY + 1)) begin
            out_data  <= acc;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else
            drain_cnt <= drain_cnt + DW'(1);
        end
        HOLD: if (out_fire) begin
          out_valid <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fusion_array_tile.sv
// Directed + randomized bench for fusion_array_tile against a plain-arithmetic dot-product model.
module tb_fusion_array_tile;
  localparam int N    = 8;
  localparam int ACC  = 64;
  localparam int L    = 2;
  localparam int MAXB = 256;
  localparam int VW   = N * ACC;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0, cfg_ready;
  logic [3:0]         cfg_in_width = 4'd8, cfg_weight_width = 4'd8;
  logic               cfg_s_in = 1'b0, cfg_s_weight = 1'b0;
  logic               w_valid = 1'b0, w_ready;
  logic [N*N*8-1:0]   w_data = '0;
  logic               in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [N*8-1:0]     in_data = '0;
  logic               out_valid, out_ready = 1'b0;
  logic [VW-1:0]      out_data;
  logic               busy, err;

  fusion_array_tile #(.ARRAY_SIZE(N), .COL_WIDTH(13), .ACC_WIDTH(ACC), .SA_LATENCY(L), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int              vectors = 0, miscompares = 0;
  logic [7:0]      w_arr [N][N];
  logic [N*8-1:0]  beats [$];
  longint          exp_col [N];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint dec(input logic [7:0] b, input int w, input bit s);
    longint v;
    v = longint'(b) % (longint'(1) << w);
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic int eff(input logic [3:0] w);
    return (w == 4'd1 || w == 4'd2 || w == 4'd4 || w == 4'd8) ? int'(w) : 8;
  endfunction

  task automatic model(input int iw, input int ww, input bit si, input bit sw, input int nb);
    for (int c = 0; c < N; c++) exp_col[c] = 0;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          exp_col[c] += dec(beats[b][r*8 +: 8], iw, si) * dec(w_arr[r][c], ww, sw);
  endtask

  task automatic send_cfg(input logic [3:0] iw, input logic [3:0] ww, input bit si, input bit sw);
    int n = 0;
    cfg_in_width = iw; cfg_weight_width = ww; cfg_s_in = si; cfg_s_weight = sw; cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin step(); n++; end
    chk("cfg_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("busy_after_cfg", busy, 1);
  endtask

  task automatic send_w();
    int n = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) w_data[(r*N + c)*8 +: 8] = w_arr[r][c];
    w_valid = 1'b1;
    while (!w_ready && n < 50) begin step(); n++; end
    chk("w_ready", w_ready, 1);
    step();
    w_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [N*8-1:0] d, input bit last);
    int n = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("in_ready", in_ready, 1);
    step();
  endtask

  task automatic run_tile(input logic [3:0] iw, input logic [3:0] ww, input bit si, input bit sw,
                          input int gap_max, input bit overrun, input bit exp_err);
    int nb, n;
    logic [VW-1:0] exp_vec;
    nb = overrun ? MAXB : beats.size();
    model(eff(iw), eff(ww), si, sw, nb);
    for (int c = 0; c < N; c++) exp_vec[c*ACC +: ACC] = exp_col[c];
    send_cfg(iw, ww, si, sw);
    send_w();
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) step();
      send_beat(beats[b], !overrun && b == nb - 1);
    end
    // Overrun keeps offering beats; they must all be refused.
    in_valid = overrun; in_last = 1'b0; in_data = '1;
    n = 0;
    while (!out_valid && n < 40) begin
      step(); n++;
      if (overrun) chk("overrun_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("latency", n, L + 2);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp_vec);
    chk("err", err, exp_err);
    repeat (10) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp_vec);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_cfg_ready", cfg_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  task automatic rand_fill(input int nb);
    beats.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) w_arr[r][c] = 8'($urandom_range(255, 0));
    for (int b = 0; b < nb; b++) beats.push_back({$urandom, $urandom});
  endtask

  initial begin
    int wsel [4] = '{1, 2, 4, 8};
    repeat (3) step();
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // 8b/8b unsigned identity, single all-ones beat
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) w_arr[r][c] = (r == c) ? 8'h01 : 8'h00;
    beats.delete();
    beats.push_back({N{8'h01}});
    run_tile(4'd8, 4'd8, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // 4b/4b signed, weights -1, three beats of 2 with gaps
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) w_arr[r][c] = 8'h0F;
    beats.delete();
    repeat (3) beats.push_back({N{8'h02}});
    run_tile(4'd4, 4'd4, 1'b1, 1'b1, 2, 1'b0, 1'b0);

    repeat (5) begin
      rand_fill($urandom_range(6, 1));
      run_tile(4'(wsel[$urandom_range(3, 0)]), 4'(wsel[$urandom_range(3, 0)]),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 3, 1'b0, 1'b0);
    end

    // Illegal activation width runs as 8b and flags err
    rand_fill(3);
    run_tile(4'd3, 4'd8, 1'b1, 1'b0, 1, 1'b0, 1'b1);

    // Reset mid-STREAM abandons the tile
    rand_fill(2);
    send_cfg(4'd8, 4'd8, 1'b0, 1'b0);
    send_w();
    send_beat(beats[0], 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_err", err, 0);
    rst_n = 1'b1;
    step();

    rand_fill(4);
    run_tile(4'd8, 4'd2, 1'b0, 1'b1, 2, 1'b0, 1'b0);

    // MAX_BEATS without in_last: forced close, err, further beats refused
    rand_fill(MAXB);
    run_tile(4'd8, 4'd8, 1'b0, 1'b0, 0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
